// File: rtl/cpu_pkg.sv
// Shared CPU types: register-file geometry and the
// write-back entry carried from execute to retirement.
package cpu_pkg;

  localparam int DATA_W = 19;
  localparam int ADDR_W = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular storage for pending write-backs.
// Exposes every slot so the parent can search them.
module wb_fifo
  import cpu_pkg::*;
#(
  parameter type T = wb_entry_t,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  T                         wdata,
  output T                         head,
  output T [DEPTH-1:0]             ents,
  output logic [$clog2(DEPTH)-1:0] rp,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] wp;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(DEPTH));
  // a full queue refuses a push even if it pops that edge
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = ents[rp];

  always_ff @(posedge clk) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && do_push) ents[wp] <= wdata;
  end

endmodule

// File: rtl/wb_queue.sv
// Write-back queue: buffers results until the RF port
// is free and forwards the youngest pending value.
module wb_queue
  import cpu_pkg::*;
#(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_W-1:0]        in_rd_addr,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     drain_en,
  output logic                     rf_we,
  output logic [ADDR_W-1:0]        rf_rd_addr,
  output logic [DATA_W-1:0]        rf_wd,
  input  logic [ADDR_W-1:0]        rs1_addr,
  input  logic [ADDR_W-1:0]        rs2_addr,
  output logic                     fwd1_hit,
  output logic [DATA_W-1:0]        fwd1_data,
  output logic                     fwd2_hit,
  output logic [DATA_W-1:0]        fwd2_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t              wdata;
  entry_t              head;
  entry_t [DEPTH-1:0]  ents;
  logic   [PW-1:0]     rp;
  logic                push;

  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign wdata    = '{addr: in_rd_addr, data: in_data};

  // entries being discarded by reset must never reach the RF
  assign rf_we      = !rst && !empty && drain_en;
  assign rf_rd_addr = empty ? '0 : head.addr;
  assign rf_wd      = empty ? '0 : head.data;

  wb_fifo #(
    .T     (entry_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (rf_we),
    .wdata (wdata),
    .head  (head),
    .ents  (ents),
    .rp    (rp),
    .count (count),
    .empty (empty),
    .full  (full)
  );

  // walk oldest to youngest so the last match wins
  always_comb begin
    logic [PW-1:0] idx;
    idx       = '0;
    fwd1_hit  = 1'b0;
    fwd1_data = '0;
    fwd2_hit  = 1'b0;
    fwd2_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rp + PW'(i);
      if ((PW+1)'(i) < count) begin
        if (ents[idx].addr == rs1_addr) begin
          fwd1_hit  = 1'b1;
          fwd1_data = ents[idx].data;
        end
        if (ents[idx].addr == rs2_addr) begin
          fwd2_hit  = 1'b1;
          fwd2_data = ents[idx].data;
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_queue.sv
// Self-checking bench for wb_queue against a
// queue-based reference model.
module tb_wb_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_rd_addr;
  logic [18:0] in_data;
  logic        drain_en;
  logic        rf_we;
  logic [3:0]  rf_rd_addr;
  logic [18:0] rf_wd;
  logic [3:0]  rs1_addr;
  logic [3:0]  rs2_addr;
  logic        fwd1_hit;
  logic [18:0] fwd1_data;
  logic        fwd2_hit;
  logic [18:0] fwd2_data;
  logic [2:0]  count;
  logic        empty;
  logic        full;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [3:0]  a;
    logic [18:0] d;
  } ent_t;

  ent_t q[$];

  always #5 clk = ~clk;

  wb_queue dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_rd_addr (in_rd_addr),
    .in_data    (in_data),
    .drain_en   (drain_en),
    .rf_we      (rf_we),
    .rf_rd_addr (rf_rd_addr),
    .rf_wd      (rf_wd),
    .rs1_addr   (rs1_addr),
    .rs2_addr   (rs2_addr),
    .fwd1_hit   (fwd1_hit),
    .fwd1_data  (fwd1_data),
    .fwd2_hit   (fwd2_hit),
    .fwd2_data  (fwd2_data),
    .count      (count),
    .empty      (empty),
    .full       (full)
  );

  // advance one edge, applying the same edge to the model
  task automatic tick();
    bit   do_pop;
    bit   do_push;
    ent_t e;
    do_pop  = !rst && drain_en && q.size() > 0;
    do_push = !rst && in_valid && q.size() < 4;
    e.a = in_rd_addr;
    e.d = in_data;
    @(posedge clk);
    if (rst) q.delete();
    else begin
      if (do_pop)  q.delete(0);
      if (do_push) q.push_back(e);
    end
    #1;
  endtask

  function automatic bit m_hit(logic [3:0] a);
    foreach (q[i]) if (q[i].a == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [18:0] m_data(logic [3:0] a);
    logic [18:0] r = '0;
    foreach (q[i]) if (q[i].a == a) r = q[i].d;
    return r;
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; drain_en = 1'b1;
    in_rd_addr = '0; in_data = '0;
    rs1_addr = '0; rs2_addr = '0;
    tick(); tick();
    rst = 1'b0; #1;
    checks++;
    if (rf_we !== 1'b0) begin
      fails++; $display("FAIL rst_rf_we got=%0h exp=0", rf_we);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      fails++; $display("FAIL rst_in_ready got=%0h exp=1", in_ready);
    end
    checks++;
    if (empty !== 1'b1 || full !== 1'b0) begin
      fails++; $display("FAIL rst_flags got=%0b%0b exp=10", empty, full);
    end
    checks++;
    if (count !== 3'd0) begin
      fails++; $display("FAIL rst_count got=%0d exp=0", count);
    end
    checks++;
    if (fwd1_hit !== 1'b0 || fwd2_hit !== 1'b0) begin
      fails++; $display("FAIL rst_fwd_hit got=%0b%0b exp=00", fwd1_hit, fwd2_hit);
    end
    checks++;
    if (rf_wd !== '0 || rf_rd_addr !== '0 || fwd1_data !== '0 || fwd2_data !== '0) begin
      fails++; $display("FAIL rst_data got=%0h/%0h/%0h/%0h exp=0", rf_rd_addr, rf_wd, fwd1_data, fwd2_data);
    end
  endtask

  task automatic test_single();
    drain_en = 1'b1;
    in_valid = 1'b1; in_rd_addr = 4'd3; in_data = 19'h12345;
    tick();
    in_valid = 1'b0; #1;
    checks++;
    if (rf_we !== 1'b1) begin
      fails++; $display("FAIL single_we got=%0h exp=1", rf_we);
    end
    checks++;
    if (rf_rd_addr !== 4'd3) begin
      fails++; $display("FAIL single_addr got=%0h exp=3", rf_rd_addr);
    end
    checks++;
    if (rf_wd !== 19'h12345) begin
      fails++; $display("FAIL single_wd got=%0h exp=12345", rf_wd);
    end
    tick();
    checks++;
    if (empty !== 1'b1 || rf_we !== 1'b0) begin
      fails++; $display("FAIL single_drained got=%0b%0b exp=10", empty, rf_we);
    end
  endtask

  task automatic test_full();
    ent_t exp[4];
    drain_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp[i].a = 4'($urandom);
      exp[i].d = 19'($urandom);
      in_valid = 1'b1; in_rd_addr = exp[i].a; in_data = exp[i].d;
      tick();
    end
    in_valid = 1'b0; #1;
    checks++;
    if (full !== 1'b1 || in_ready !== 1'b0 || count !== 3'd4) begin
      fails++; $display("FAIL full_flags got=%0b%0b%0d exp=104", full, in_ready, count);
    end
    in_valid = 1'b1; in_rd_addr = 4'hF; in_data = 19'h7FFFF;
    drain_en = 1'b1;
    // pop and 5th offer share an edge: the offer must be refused
    #1;
    tick();
    in_valid = 1'b0;
    drain_en = 1'b0; #1;
    checks++;
    if (count !== 3'd3) begin
      fails++; $display("FAIL full_reject got=%0d exp=3", count);
    end
    drain_en = 1'b1;
    for (int i = 1; i < 4; i++) begin
      #1;
      checks++;
      if (rf_we !== 1'b1 || rf_rd_addr !== exp[i].a || rf_wd !== exp[i].d) begin
        fails++;
        $display("FAIL full_order%0d got=%0b/%0h/%0h exp=1/%0h/%0h",
                 i, rf_we, rf_rd_addr, rf_wd, exp[i].a, exp[i].d);
      end
      tick();
    end
    checks++;
    if (empty !== 1'b1) begin
      fails++; $display("FAIL full_empty got=%0b exp=1", empty);
    end
  endtask

  task automatic test_forward();
    drain_en = 1'b0;
    in_valid = 1'b1; in_rd_addr = 4'd5; in_data = 19'h00AAA;
    tick();
    in_data = 19'h00BBB;
    tick();
    in_valid = 1'b0;
    rs1_addr = 4'd5; rs2_addr = 4'd6; #1;
    checks++;
    if (fwd1_hit !== 1'b1 || fwd1_data !== 19'h00BBB) begin
      fails++; $display("FAIL fwd1 got=%0b/%0h exp=1/bbb", fwd1_hit, fwd1_data);
    end
    checks++;
    if (fwd2_hit !== 1'b0 || fwd2_data !== '0) begin
      fails++; $display("FAIL fwd2 got=%0b/%0h exp=0/0", fwd2_hit, fwd2_data);
    end
    drain_en = 1'b1;
    tick(); tick();
    checks++;
    if (empty !== 1'b1 || fwd1_hit !== 1'b0) begin
      fails++; $display("FAIL fwd_drained got=%0b%0b exp=10", empty, fwd1_hit);
    end
  endtask

  task automatic test_back_to_back();
    drain_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_rd_addr = 4'($urandom); in_data = 19'($urandom);
      tick();
    end
    drain_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_rd_addr = 4'($urandom); in_data = 19'($urandom);
      #1;
      checks++;
      if (count !== 3'd2 || rf_we !== 1'b1 || rf_rd_addr !== q[0].a || rf_wd !== q[0].d) begin
        fails++;
        $display("FAIL b2b%0d got=%0d/%0b/%0h/%0h exp=2/1/%0h/%0h",
                 i, count, rf_we, rf_rd_addr, rf_wd, q[0].a, q[0].d);
      end
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (rf_rd_addr !== q[0].a || rf_wd !== q[0].d) begin
        fails++; $display("FAIL b2b_tail%0d got=%0h/%0h exp=%0h/%0h", i, rf_rd_addr, rf_wd, q[0].a, q[0].d);
      end
      tick();
    end
    checks++;
    if (empty !== 1'b1) begin
      fails++; $display("FAIL b2b_empty got=%0b exp=1", empty);
    end
  endtask

  task automatic test_reset_mid();
    drain_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_rd_addr = 4'($urandom); in_data = 19'($urandom);
      tick();
    end
    checks++;
    if (count !== 3'd3) begin
      fails++; $display("FAIL mid_fill got=%0d exp=3", count);
    end
    rst = 1'b1; drain_en = 1'b1; #1;
    checks++;
    if (rf_we !== 1'b0) begin
      fails++; $display("FAIL mid_rst_we got=%0b exp=0", rf_we);
    end
    tick();
    rst = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (rf_we !== 1'b0 || count !== 3'd0) begin
        fails++; $display("FAIL mid_after%0d got=%0b/%0d exp=0/0", i, rf_we, count);
      end
      tick();
    end
  endtask

  task automatic test_random();
    bit exp_we;
    for (int n = 0; n < 400; n++) begin
      rst        = ($urandom_range(0, 59) == 0);
      in_valid   = 1'($urandom_range(0, 1));
      drain_en   = ($urandom_range(0, 2) != 0) ? 1'b0 : 1'b1;
      in_rd_addr = 4'($urandom_range(0, 7));
      in_data    = 19'($urandom);
      rs1_addr   = 4'($urandom_range(0, 7));
      rs2_addr   = 4'($urandom_range(0, 7));
      #1;
      exp_we = !rst && drain_en && q.size() > 0;
      checks++;
      if (rf_we !== exp_we || count !== 3'(q.size()) ||
          empty !== (q.size() == 0) || full !== (q.size() == 4) ||
          in_ready !== (q.size() != 4)) begin
        fails++;
        $display("FAIL rnd_status%0d got=%0b/%0d/%0b%0b%0b exp=%0b/%0d",
                 n, rf_we, count, empty, full, in_ready, exp_we, q.size());
      end
      if (q.size() > 0) begin
        checks++;
        if (rf_rd_addr !== q[0].a || rf_wd !== q[0].d) begin
          fails++;
          $display("FAIL rnd_head%0d got=%0h/%0h exp=%0h/%0h", n, rf_rd_addr, rf_wd, q[0].a, q[0].d);
        end
      end
      checks++;
      if (fwd1_hit !== m_hit(rs1_addr) || fwd1_data !== m_data(rs1_addr)) begin
        fails++;
        $display("FAIL rnd_fwd1_%0d got=%0b/%0h exp=%0b/%0h",
                 n, fwd1_hit, fwd1_data, m_hit(rs1_addr), m_data(rs1_addr));
      end
      checks++;
      if (fwd2_hit !== m_hit(rs2_addr) || fwd2_data !== m_data(rs2_addr)) begin
        fails++;
        $display("FAIL rnd_fwd2_%0d got=%0b/%0h exp=%0b/%0h",
                 n, fwd2_hit, fwd2_data, m_hit(rs2_addr), m_data(rs2_addr));
      end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_full();
    test_forward();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/wb_queue.md
WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 The block SHALL have parameter DATA_W, default 19, meaning register data width.
REQ-002 The block SHALL have parameter ADDR_W, default 4, meaning register address width (16 registers).
REQ-003 The block SHALL have parameter DEPTH, default 4, meaning queue entries; the value SHALL be a power of two, 2 or greater.
REQ-004 The block SHALL have port clk, input, 1, meaning the single clock; all state SHALL update on the rising edge.
REQ-005 The block SHALL have port rst, input, 1, meaning reset; reset is synchronous and active-high.
REQ-006 The block SHALL have port in_valid, input, 1, meaning a result is offered.
REQ-007 The block SHALL have port in_ready, output, 1, meaning the queue can accept a result.
REQ-008 The block SHALL have port in_rd_addr, input, ADDR_W, meaning the destination register.
REQ-009 The block SHALL have port in_data, input, DATA_W, meaning the result value.
REQ-010 The block SHALL have port drain_en, input, 1, meaning the register file write port is available this cycle.
REQ-011 The block SHALL have ports rf_we (1), rf_rd_addr (ADDR_W) and rf_wd (DATA_W), all outputs, meaning the register file write port.
REQ-012 The block SHALL have ports rs1_addr and rs2_addr, inputs, ADDR_W, meaning the forwarding lookup addresses.
REQ-013 The block SHALL have ports fwd1_hit and fwd2_hit (1) and fwd1_data and fwd2_data (DATA_W), all outputs, meaning a pending-write match and its value.
REQ-014 The block SHALL have ports count (clog2(DEPTH)+1), empty (1) and full (1), all outputs, meaning queue occupancy status.

Function
REQ-015 The block SHALL implement a circular FIFO with head/tail pointers that wrap modulo DEPTH.
REQ-016 in_ready SHALL equal !full, combinationally; when full, a push SHALL NOT be accepted, even if a pop occurs in the same cycle.
REQ-017 A push SHALL occur when in_valid && in_ready, storing {in_rd_addr, in_data} at tail on the clock edge.
REQ-018 rf_we SHALL equal !empty && drain_en, combinationally, and rf_rd_addr/rf_wd SHALL present the head entry whenever !empty.
REQ-019 A pop SHALL occur on every edge where rf_we=1; the head entry is consumed on that edge.
REQ-020 Minimum latency SHALL be one cycle: a result pushed at edge N SHALL drive rf_we during cycle N+1 if it is the head and drain_en=1.
REQ-021 A simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-022 Ordering SHALL be strictly FIFO, so that duplicate destination addresses retire oldest first.
REQ-023 The forwarding lookup SHALL compare rsN_addr against all valid entries; fwdN_hit=1 on any match, and fwdN_data SHALL come from the youngest matching entry.
REQ-024 The forwarding lookup SHALL be combinational, SHALL cover queued entries only (not the same-cycle incoming result), and SHALL NOT treat any register specially.
REQ-025 When empty, the forwarding outputs SHALL be fwdN_hit=0 and fwdN_data=0; fwdN_data SHALL be 0 whenever fwdN_hit=0.
REQ-026 count SHALL be the number of valid entries, 0..DEPTH, with empty=(count==0) and full=(count==DEPTH).

Reset
REQ-027 While rst=1, the pointers and count SHALL be cleared and all entries invalidated; pending writes are discarded.
REQ-028 During and after reset: rf_we=0, in_ready=1, empty=1, full=0, count=0, fwdN_hit=0 and all data outputs 0.
REQ-029 Reset asserted mid-operation SHALL take priority over a simultaneous push or pop on the same edge.

Structure
REQ-030 DATA_W, ADDR_W and a packed wb_entry_t {addr, data} typedef SHALL live in the shared package cpu_pkg.
REQ-031 The storage and pointer logic SHALL be the sub-module wb_fifo; wb_queue SHALL add the drain control and the forwarding search.

Verification
REQ-032 The bench SHALL cover: after reset, push {3, 0x12345} with drain_en=1 -> rf_we=1, rf_rd_addr=3 and rf_wd=0x12345 in the next cycle; then empty=1.
REQ-033 The bench SHALL cover: with drain_en=0, push 4 entries -> full=1, in_ready=0, count=4; a 5th offer is not accepted; raising drain_en retires the entries in push order.
REQ-034 The bench SHALL cover: with drain_en=0, push {5,0x00AAA} then {5,0x00BBB}, rs1_addr=5 -> fwd1_hit=1, fwd1_data=0x00BBB; fwd2 with rs2_addr=6 -> fwd2_hit=0.
REQ-035 The bench SHALL cover: with count=2 and drain_en=1, push on every cycle for 10 cycles -> count stays 2 and pointers wrap without loss or reorder.
REQ-036 The bench SHALL cover: with 3 entries queued, assert rst for 1 cycle -> next cycle rf_we=0, count=0 and no discarded entry is ever written.
